// File: rtl/mac_pkg.sv
// Shared definitions for the systolic MAC array: instruction word layout.
package mac_pkg;

   localparam int INST_W    = 3;
   localparam int INST_LOAD = 0;
   localparam int INST_EXEC = 1;
   localparam int INST_CLR  = 2;

   typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/mac_array_if.sv
// Data/instruction bundle between the array and its driver.
interface mac_array_if
   import mac_pkg::*;
#(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int row     = 8
) ();

   logic [bw*row-1:0]      in_w;
   logic [psum_bw*col-1:0] in_n;
   inst_t                  inst_w;
   logic [psum_bw*col-1:0] out_s;
   logic [col-1:0]         valid;

   modport master (output in_w, in_n, inst_w, input out_s, valid);
   modport slave  (input in_w, in_n, inst_w, output out_s, valid);

endinterface

// File: rtl/mac_tile.sv
// One processing element: holds a signed weight, multiplies the passing
// activation and accumulates onto the partial sum arriving from the north.
module mac_tile
   import mac_pkg::*;
#(
   parameter int bw      = 4,
   parameter int psum_bw = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [bw-1:0]      in_w,
   input  logic [psum_bw-1:0] in_n,
   input  inst_t              inst_in,
   output logic [bw-1:0]      out_e,
   output inst_t              inst_e,
   output logic [psum_bw-1:0] out_s
);

   logic [bw-1:0]             a_q;
   logic signed [bw-1:0]      b_q;
   logic [psum_bw-1:0]        c_q;
   inst_t                     inst_q;
   logic                      load_ready_q;

   // Activation is unsigned (zero-extended), weight is signed; product wraps at psum_bw.
   logic signed [psum_bw-1:0] act_ext;
   logic signed [psum_bw-1:0] wgt_ext;
   logic [psum_bw-1:0]        mac_sum;

   assign act_ext = psum_bw'($signed({1'b0, in_w}));
   assign wgt_ext = psum_bw'(b_q);
   assign mac_sum = in_n + $unsigned(act_ext * wgt_ext);

   // Clear beats execute beats load; the load token is only passed east
   // once this tile already owns its weight, so a row fills from column 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_q          <= '0;
         b_q          <= '0;
         c_q          <= '0;
         inst_q       <= '0;
         load_ready_q <= 1'b1;
      end else begin
         inst_q[INST_EXEC] <= inst_in[INST_EXEC];
         inst_q[INST_CLR]  <= inst_in[INST_CLR];
         inst_q[INST_LOAD] <= load_ready_q ? 1'b0 : inst_in[INST_LOAD];
         if (inst_in[INST_CLR]) begin
            b_q          <= '0;
            load_ready_q <= 1'b1;
         end else if (inst_in[INST_EXEC]) begin
            a_q <= in_w;
            c_q <= mac_sum;
         end else if (inst_in[INST_LOAD]) begin
            a_q <= in_w;
            if (load_ready_q) begin
               b_q          <= in_w;
               load_ready_q <= 1'b0;
            end
         end
      end
   end

   assign out_e  = a_q;
   assign inst_e = inst_q;
   assign out_s  = c_q;

endmodule

// File: rtl/mac_array.sv
// row x col grid of MAC tiles. Activations and instructions travel east,
// partial sums travel south; each row sees the instruction one cycle later
// than the row above so it meets the partial sums coming down.
module mac_array
   import mac_pkg::*;
#(
   parameter int bw      = 4,
   parameter int psum_bw = 16,
   parameter int col     = 8,
   parameter int row     = 8
) (
   input  logic        clk,
   input  logic        reset,
   mac_array_if.slave  bus
);

   inst_t              skew_q [row];
   logic [bw-1:0]      a_h    [row][col];
   inst_t              i_h    [row][col];
   logic [psum_bw-1:0] c_v    [row][col];

   // Instruction delay line: skew_q[r] feeds row r+1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < row; r++) skew_q[r] <= '0;
      end else begin
         skew_q[0] <= bus.inst_w;
         for (int r = 1; r < row; r++) skew_q[r] <= skew_q[r-1];
      end
   end

   for (genvar r = 0; r < row; r++) begin : g_row
      inst_t row_inst;

      if (r == 0) begin : g_first
         assign row_inst = bus.inst_w;
      end else begin : g_skewed
         assign row_inst = skew_q[r-1];
      end

      for (genvar c = 0; c < col; c++) begin : g_col
         logic [bw-1:0]      w_in;
         inst_t              i_in;
         logic [psum_bw-1:0] n_in;

         if (c == 0) begin : g_edge
            assign w_in = bus.in_w[bw*r +: bw];
            assign i_in = row_inst;
         end else begin : g_inner
            assign w_in = a_h[r][c-1];
            assign i_in = i_h[r][c-1];
         end

         if (r == 0) begin : g_top
            assign n_in = bus.in_n[psum_bw*c +: psum_bw];
         end else begin : g_below
            assign n_in = c_v[r-1][c];
         end

         mac_tile #(.bw(bw), .psum_bw(psum_bw)) u_tile (
            .clk     (clk),
            .reset   (reset),
            .in_w    (w_in),
            .in_n    (n_in),
            .inst_in (i_in),
            .out_e   (a_h[r][c]),
            .inst_e  (i_h[r][c]),
            .out_s   (c_v[r][c])
         );
      end
   end

   for (genvar c = 0; c < col; c++) begin : g_out
      assign bus.out_s[psum_bw*c +: psum_bw] = c_v[row-1][c];
      assign bus.valid[c]                    = i_h[row-1][c][INST_EXEC];
   end

endmodule

// File: tb/tb_mac_array.sv
// Scoreboard bench for mac_array: three small configurations (1x2 for load
// order / execute / clear / reset, 1x1 with 8-bit sums for wrap-around,
// 4x1 for row skew). Expected results are queued at issue time and popped
// by a monitor whenever a valid bit is seen.
module tb_mac_array;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;

   logic [15:0] q_a0 [$];
   logic [15:0] q_a1 [$];
   logic [7:0]  q_w  [$];
   logic [15:0] s_val [$];
   int          s_cyc [$];

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to time the row-skew result
   always @(posedge clk) cyc <= cyc + 1;

   mac_array_if #(.bw(4), .psum_bw(16), .col(2), .row(1)) if_a ();
   mac_array_if #(.bw(4), .psum_bw(8),  .col(1), .row(1)) if_w ();
   mac_array_if #(.bw(4), .psum_bw(16), .col(1), .row(4)) if_s ();

   mac_array #(.bw(4), .psum_bw(16), .col(2), .row(1)) dut_a (.clk(clk), .reset(rst_n), .bus(if_a));
   mac_array #(.bw(4), .psum_bw(8),  .col(1), .row(1)) dut_w (.clk(clk), .reset(rst_n), .bus(if_w));
   mac_array #(.bw(4), .psum_bw(16), .col(1), .row(4)) dut_s (.clk(clk), .reset(rst_n), .bus(if_s));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: valid seen with no expected result queued", name);
   endtask

   task automatic monitor_step();
      if (if_a.valid[0] === 1'b1) begin
         if (q_a0.size() == 0) unexpected("a_col0");
         else check("a_col0", 32'(if_a.out_s[15:0]), 32'(q_a0.pop_front()));
      end
      if (if_a.valid[1] === 1'b1) begin
         if (q_a1.size() == 0) unexpected("a_col1");
         else check("a_col1", 32'(if_a.out_s[31:16]), 32'(q_a1.pop_front()));
      end
      if (if_w.valid[0] === 1'b1) begin
         if (q_w.size() == 0) unexpected("w_col0");
         else check("w_col0", 32'(if_w.out_s), 32'(q_w.pop_front()));
      end
      if (if_s.valid[0] === 1'b1) begin
         if (s_val.size() == 0) unexpected("s_col0");
         else begin
            check("s_cycle", cyc, s_cyc.pop_front());
            check("s_val", 32'(if_s.out_s), 32'(s_val.pop_front()));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [2:0] inst, input logic [3:0] w, input logic [15:0] n);
      if_a.inst_w = inst;
      if_a.in_w   = w;
      if_a.in_n   = {n, n};
   endtask

   task automatic drive_w(input logic [2:0] inst, input logic [3:0] w, input logic [7:0] n);
      if_w.inst_w = inst;
      if_w.in_w   = w;
      if_w.in_n   = n;
   endtask

   task automatic drive_s(input logic [2:0] inst, input logic [15:0] w, input logic [15:0] n);
      if_s.inst_w = inst;
      if_s.in_w   = w;
      if_s.in_n   = n;
   endtask

   initial begin
      drive_a(3'b000, 4'h0, 16'h0000);
      drive_w(3'b000, 4'h0, 8'h00);
      drive_s(3'b000, 16'h0000, 16'h0000);

      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
      join_none

      // reset state
      #2;
      check("rst_a_out", 32'(if_a.out_s), 32'h0);
      check("rst_a_valid", 32'(if_a.valid), 32'h0);
      check("rst_s_out", 32'(if_s.out_s), 32'h0);
      check("rst_w_valid", 32'(if_w.valid), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;

      // load order: A -> tile0 (-6), 3 -> tile1, 7 -> ignored
      drive_a(3'b001, 4'hA, 16'h0); tick();
      drive_a(3'b001, 4'h3, 16'h0); tick();
      drive_a(3'b001, 4'h7, 16'h0); tick();
      drive_a(3'b000, 4'h0, 16'h0); tick(); tick();

      // execute a=2, n=0: -12 and 6
      drive_a(3'b010, 4'h2, 16'h0);
      q_a0.push_back(16'hFFF4); q_a1.push_back(16'h0006);
      tick();
      drive_a(3'b000, 4'h0, 16'h0); tick(); tick(); tick();

      // execute a=15, n=0x10: 16-90 and 16+45
      drive_a(3'b010, 4'hF, 16'h0010);
      q_a0.push_back(16'hFFB6); q_a1.push_back(16'h003D);
      tick();
      drive_a(3'b000, 4'h0, 16'h0010); tick(); tick();
      drive_a(3'b000, 4'h0, 16'h0000); tick();

      // back-to-back execute a=1 then a=4
      drive_a(3'b010, 4'h1, 16'h0);
      q_a0.push_back(16'hFFFA); q_a1.push_back(16'h0003);
      tick();
      drive_a(3'b010, 4'h4, 16'h0);
      q_a0.push_back(16'hFFE8); q_a1.push_back(16'h000C);
      tick();
      drive_a(3'b000, 4'h0, 16'h0); tick(); tick(); tick();

      // clear, then load+execute together: execute wins, weights stay 0
      drive_a(3'b100, 4'h0, 16'h0); tick();
      drive_a(3'b000, 4'h0, 16'h0); tick(); tick();
      drive_a(3'b011, 4'h3, 16'h0);
      q_a0.push_back(16'h0000); q_a1.push_back(16'h0000);
      tick();
      drive_a(3'b000, 4'h0, 16'h0); tick(); tick();

      // reload 5, 2 and read back with a=1
      drive_a(3'b001, 4'h5, 16'h0); tick();
      drive_a(3'b001, 4'h2, 16'h0); tick();
      drive_a(3'b000, 4'h0, 16'h0); tick(); tick();
      drive_a(3'b010, 4'h1, 16'h0);
      q_a0.push_back(16'h0005); q_a1.push_back(16'h0002);
      tick();
      drive_a(3'b000, 4'h0, 16'h0); tick(); tick(); tick();

      // async reset in the middle of an execute
      drive_a(3'b010, 4'h1, 16'h0); tick();
      drive_a(3'b000, 4'h0, 16'h0);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out", 32'(if_a.out_s), 32'h0);
      check("midrst_valid", 32'(if_a.valid), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // fresh load after reset must start at tile0: 4, 9(-7)
      drive_a(3'b001, 4'h4, 16'h0); tick();
      drive_a(3'b001, 4'h9, 16'h0); tick();
      drive_a(3'b000, 4'h0, 16'h0); tick(); tick();
      drive_a(3'b010, 4'h1, 16'h0);
      q_a0.push_back(16'h0004); q_a1.push_back(16'hFFF9);
      tick();
      drive_a(3'b000, 4'h0, 16'h0); tick(); tick(); tick();

      // 8-bit wrap: weight 7, a=15, n=0x7F -> 0x7F+0x69
      drive_w(3'b001, 4'h7, 8'h00); tick();
      drive_w(3'b000, 4'h0, 8'h00); tick();
      drive_w(3'b010, 4'hF, 8'h7F); q_w.push_back(8'hE8); tick();
      drive_w(3'b000, 4'h0, 8'h00); tick();
      // weight -8: n=0x80 -> 0x80-120 wraps to 0x08; n=0x10 -> -104
      drive_w(3'b100, 4'h0, 8'h00); tick();
      drive_w(3'b001, 4'h8, 8'h00); tick();
      drive_w(3'b000, 4'h0, 8'h00); tick();
      drive_w(3'b010, 4'hF, 8'h80); q_w.push_back(8'h08); tick();
      drive_w(3'b010, 4'hF, 8'h10); q_w.push_back(8'h98); tick();
      drive_w(3'b000, 4'h0, 8'h00); tick(); tick();

      // row skew: one execute pulse into a 4-row column appears 4 cycles later
      drive_s(3'b010, 16'h0000, 16'h0005);
      s_cyc.push_back(cyc + 4); s_val.push_back(16'h0005);
      tick();
      drive_s(3'b000, 16'h0000, 16'h0000);
      repeat (10) tick();

      check("drain_a0", q_a0.size(), 0);
      check("drain_a1", q_a1.size(), 0);
      check("drain_w", q_w.size(), 0);
      check("drain_s", s_val.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
